// File: rtl/ysyx_23060077_icache.sv
// Direct-mapped read-only instruction cache between the IFU fetch port and the AXI read arbiter.
// Whole-line burst refill, fence.i invalidation, hit/miss performance counters.
module ysyx_23060077_icache #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fence_i,
   input  logic                  ifu_r_valid_i,
   input  logic [ADDR_WIDTH-1:0] ifu_r_addr_i,
   input  logic [7:0]            ifu_r_len_i,
   output logic                  ifu_r_ready_o,
   output logic [DATA_WIDTH-1:0] ifu_r_data_o,
   output logic                  ifu_r_last_o,
   output logic                  mem_r_valid_o,
   output logic [ADDR_WIDTH-1:0] mem_r_addr_o,
   output logic [7:0]            mem_r_len_o,
   input  logic                  mem_r_ready_i,
   input  logic [DATA_WIDTH-1:0] mem_r_data_i,
   input  logic                  mem_r_last_i,
   output logic [31:0]           hit_cnt_o,
   output logic [31:0]           miss_cnt_o
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;

   typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;
   state_t state, state_nxt;

   logic [TAG_W-1:0]      req_tag;
   logic [IDX_W-1:0]      req_idx;
   logic [OFF_W-1:0]      req_off;
   logic [SETS-1:0]       line_vld;
   logic [TAG_W-1:0]      tag_arr  [SETS];
   logic [DATA_WIDTH-1:0] data_arr [SETS*LINE_WORDS];
   logic [OFF_W-1:0]      beat_cnt;
   logic                  fence_pend;
   logic                  hit, beat, beat_last;

   assign hit       = line_vld[req_idx] && (tag_arr[req_idx] == req_tag);
   assign beat      = (state == REFILL) && mem_r_ready_i;
   assign beat_last = beat && mem_r_last_i;

   assign mem_r_valid_o = (state == REFILL);
   assign mem_r_addr_o  = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
   assign mem_r_len_o   = 8'(LINE_WORDS-1);
   assign ifu_r_last_o  = ifu_r_ready_o;

   // The IFU always asks for one aligned word; len and the byte offset carry no information.
   logic unused_ok;
   assign unused_ok = ^{ifu_r_len_i, ifu_r_addr_i[1:0]};

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ifu_r_valid_i) state_nxt = LOOKUP;
         LOOKUP:  state_nxt = hit ? RESP : REFILL;
         REFILL:  if (beat_last) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         line_vld      <= '0;
         fence_pend    <= 1'b0;
         hit_cnt_o     <= '0;
         miss_cnt_o    <= '0;
         beat_cnt      <= '0;
         ifu_r_ready_o <= 1'b0;
         ifu_r_data_o  <= '0;
         req_tag       <= '0;
         req_idx       <= '0;
         req_off       <= '0;
      end else begin
         ifu_r_ready_o <= (state_nxt == RESP);
         if (state != IDLE && fence_i) fence_pend <= 1'b1;
         case (state)
            IDLE: begin
               // Invalidation lands on the same edge as the request latch, so that lookup misses.
               if (fence_pend || fence_i) begin
                  line_vld   <= '0;
                  fence_pend <= 1'b0;
               end
               if (ifu_r_valid_i) begin
                  req_tag  <= ifu_r_addr_i[ADDR_WIDTH-1 -: TAG_W];
                  req_idx  <= ifu_r_addr_i[OFF_W+2 +: IDX_W];
                  req_off  <= ifu_r_addr_i[2 +: OFF_W];
                  beat_cnt <= '0;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  hit_cnt_o    <= hit_cnt_o + 32'd1;
                  ifu_r_data_o <= data_arr[{req_idx, req_off}];
               end else begin
                  miss_cnt_o <= miss_cnt_o + 32'd1;
               end
            end
            REFILL: begin
               if (beat) begin
                  if (beat_cnt == req_off) ifu_r_data_o <= mem_r_data_i;
                  beat_cnt <= beat_cnt + 1'b1;
                  // A short burst leaves the line invalid; the response still goes out.
                  if (mem_r_last_i)
                     line_vld[req_idx] <= (beat_cnt == OFF_W'(LINE_WORDS-1));
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && beat) begin
         data_arr[{req_idx, beat_cnt}] <= mem_r_data_i;
         if (mem_r_last_i) tag_arr[req_idx] <= req_tag;
      end
   end
endmodule

// File: doc/ysyx_23060077_icache.md
Name: ysyx_23060077_icache

Overview:
Direct-mapped, read-only instruction cache between the IFU fetch port and the AXI read arbiter.
- IFU side: the IFU holds valid with a word address until it receives a single-cycle ready+last pulse carrying the instruction.
- Memory side: the cache issues whole-line burst reads using the same valid/addr/len/ready/data/last style.
- Supports fence.i invalidation and exports hit/miss counters for performance analysis.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, word/instruction width
LINE_WORDS, 4, words per line (power of 2, >=2)
SETS, 16, number of lines (power of 2)

Ports:
clk  input  1  clock
reset  input  1  sync active-high reset
fence_i  input  1  invalidate all lines (one-cycle pulse)
ifu_r_valid_i  input  1  fetch request, held until response
ifu_r_addr_i  input  ADDR_WIDTH  fetch address, word aligned
ifu_r_len_i  input  8  burst length from IFU, always 0, ignored
ifu_r_ready_o  output  1  response pulse
ifu_r_data_o  output  DATA_WIDTH  instruction, valid with ready
ifu_r_last_o  output  1  equals ifu_r_ready_o
mem_r_valid_o  output  1  refill request
mem_r_addr_o  output  ADDR_WIDTH  line-aligned refill address
mem_r_len_o  output  8  LINE_WORDS-1
mem_r_ready_i  input  1  beat valid
mem_r_data_i  input  DATA_WIDTH  beat data
mem_r_last_i  input  1  final beat
hit_cnt_o  output  32  lookup hits, wraps
miss_cnt_o  output  32  lookup misses, wraps

Behaviour:
- Reset (clk, reset synchronous active-high):
  - All line valid bits cleared, state IDLE, pending-fence cleared, counters 0.
  - ifu_r_ready_o, ifu_r_last_o, mem_r_valid_o = 0; ifu_r_data_o = 0.
- Address split (defaults):
  - word offset = addr[3:2] (log2 LINE_WORDS bits above bit 1)
  - index = addr[7:4] (next log2 SETS bits)
  - tag = remaining upper bits
  - Bits [1:0] ignored.
- Storage: data array SETS x LINE_WORDS words, tag array, valid-bit vector. Plain register arrays.
- FSM states: IDLE, LOOKUP, REFILL, RESP.
  - IDLE:
    - Pending fence or fence_i set: clear all valid bits this edge.
    - ifu_r_valid_i: latch address, go LOOKUP.
    - Fence and request in the same cycle: invalidation applies first, so the lookup misses.
  - LOOKUP: compare valid && tag.
    - Hit: hit_cnt +1, capture word, go RESP.
    - Miss: miss_cnt +1, go REFILL.
  - REFILL:
    - mem_r_valid_o = 1 until the beat with mem_r_last_i; mem_r_addr_o = {tag,index,0}; mem_r_len_o = LINE_WORDS-1.
    - Each mem_r_ready_i beat writes the data word at beat counter (0..LINE_WORDS-1), then the counter increments.
    - The word whose counter equals the latched offset is captured for the response.
    - On ready&&last: write tag, set valid, go RESP.
    - Valid is set only if the counter equals LINE_WORDS-1 at last; an early last leaves the line invalid, still responds, and the data is undefined.
  - RESP: ifu_r_ready_o = ifu_r_last_o = 1 for exactly one cycle with captured data (registered outputs); go IDLE.
- Latency:
  - Hit: response 2 cycles after valid first seen in IDLE.
  - Miss: response the cycle after the last beat.
- A request arriving in the cycle after RESP is accepted normally. The IFU deasserts valid after the pulse, so there is no duplicate response.
- fence_i arriving outside IDLE sets a pending flag, applied on the next IDLE cycle.
  - A refill in progress completes and its line is then invalidated by the pending fence.
- Reset mid-refill: refill abandoned, mem_r_valid_o low the next cycle, partially written line stays invalid.
- Counters wrap at 2^32.
- ifu_r_valid_i dropping during LOOKUP/REFILL does not cancel: the refill completes and the response pulse is still issued (the IFU ignores it).

Test Plan:
- Cold miss: after reset, request 0x3000_0000; memory returns 0x00000413, 0x00100493, 0x00200513, 0x00300593 -> mem_r_addr_o = 0x3000_0000, len = 3; response 0x00000413 one cycle after last; miss_cnt = 1.
- Hit: request 0x3000_0008 -> ifu_r_ready_o 2 cycles later with 0x00200513; no mem_r_valid_o; hit_cnt = 1.
- Critical word: request 0x3000_001C, cold -> mem_r_addr_o = 0x3000_0010; response equals beat 3.
- Conflict: fill 0x3000_0000, then request 0x3000_0100 (same index 0) -> miss and refill; a later 0x3000_0000 misses again.
- fence.i:
  - Pulse fence_i in IDLE, then re-request 0x3000_0004 -> miss.
  - Pulse fence_i during REFILL -> refill completes and responds; the next request to the same line misses.
- Reset mid-refill: assert reset after beat 1 -> mem_r_valid_o = 0 next cycle, counters 0; request to the same line misses and refills from beat 0.
